// File: rtl/williams2_rom_loader.sv
// williams2_rom_loader: takes the hps_io ioctl byte stream for the williams2
// program ROM, buffers it in a small FIFO and replays it into the ROM write
// port with a ready/valid handshake, pushing back on the HPS through
// ioctl_wait. The core is held in reset while loading and for a short settle
// period after the final memory write. Byte count, checksum and a sticky
// overflow flag are exported for the OSD/debug.
module williams2_rom_loader #(
  parameter logic [7:0]  ROM_INDEX   = 8'd0,
  parameter logic [16:0] ROM_SIZE    = 17'h1_8000,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          HOLD_CYCLES = 16
) (
  input  logic        clock_12,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [16:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        mem_we,
  output logic [16:0] mem_addr,
  output logic [7:0]  mem_data,
  input  logic        mem_ready,
  output logic        core_hold,
  output logic        load_done,
  output logic [15:0] checksum,
  output logic [17:0] byte_count,
  output logic        overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [CW-1:0] FIFO_FULL  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] WAIT_LEVEL = CW'(FIFO_DEPTH - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_HOLD,
    S_RUN
  } state_e;

  typedef struct packed {
    logic [16:0] addr;
    logic [7:0]  data;
  } entry_t;

  // Registered state
  state_e         state_q;
  logic           dl_prev_q;
  logic [HW-1:0]  hold_cnt_q;
  logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;
  logic           mem_we_q;
  logic [16:0]    mem_addr_q;
  logic [7:0]     mem_data_q;
  logic           ioctl_wait_q;
  logic           core_hold_q;
  logic           load_done_q;
  logic [15:0]    checksum_q;
  logic [17:0]    byte_count_q;
  logic           overflow_q;
  entry_t         fifo_mem [FIFO_DEPTH];

  // Next-state values
  state_e         state_d;
  logic [HW-1:0]  hold_cnt_d;
  logic [PW-1:0]  wr_ptr_d, rd_ptr_d;
  logic [CW-1:0]  count_d;
  logic           mem_we_d;
  logic [16:0]    mem_addr_d;
  logic [7:0]     mem_data_d;
  logic           ioctl_wait_d;
  logic           core_hold_d;
  logic           load_done_d;
  logic [15:0]    checksum_d;
  logic [17:0]    byte_count_d;
  logic           overflow_d;

  // Stream qualification and FIFO bookkeeping
  logic           idx_match, dl_start, accept, in_range;
  logic [CW-1:0]  count_eff;
  logic [PW-1:0]  wr_ptr_eff, rd_ptr_eff;
  logic           fifo_full, push, drop, out_load, pop;
  entry_t         head;

  assign idx_match  = (ioctl_index == ROM_INDEX);
  assign dl_start   = ioctl_download & ~dl_prev_q & idx_match;
  assign accept     = ioctl_wr & ioctl_download & idx_match &
                      ((state_q == S_LOAD) | dl_start);
  assign in_range   = (ioctl_addr < ROM_SIZE);

  // A new download flushes the FIFO, so the start cycle sees it empty.
  assign count_eff  = dl_start ? '0 : count_q;
  assign wr_ptr_eff = dl_start ? '0 : wr_ptr_q;
  assign rd_ptr_eff = dl_start ? '0 : rd_ptr_q;

  assign fifo_full  = (count_eff == FIFO_FULL);
  assign push       = accept & in_range & ~fifo_full;
  assign drop       = accept & ~push;
  // The output register may reload when empty or when its word is taken.
  assign out_load   = ~mem_we_q | mem_ready;
  assign pop        = out_load & (count_q != '0) & ~dl_start;
  assign head       = fifo_mem[rd_ptr_q];

  assign count_d    = count_eff + CW'(push) - CW'(pop);
  assign wr_ptr_d   = wr_ptr_eff + PW'(push);
  assign rd_ptr_d   = rd_ptr_eff + PW'(pop);
  assign hold_cnt_d = (state_q == S_HOLD) ? hold_cnt_q + HW'(1) : '0;

  // FSM next state and the registered control outputs derived from it
  always_comb begin
    // NOTE: every variable gets a default before any branch; a path that
    // leaves one unassigned would infer a latch.
    state_d = state_q;
    if (dl_start) begin
      state_d = S_LOAD;
    end else begin
      case (state_q)
        S_LOAD:  if (!ioctl_download) state_d = S_DRAIN;
        S_DRAIN: if ((count_q == '0) && !mem_we_q) state_d = S_HOLD;
        S_HOLD:  if (hold_cnt_q == HOLD_LAST) state_d = S_RUN;
        default: state_d = state_q;
      endcase
    end
    ioctl_wait_d = ((state_d == S_LOAD) || (state_d == S_DRAIN)) &&
                   (count_d >= WAIT_LEVEL);
    core_hold_d  = (state_d != S_RUN);
    load_done_d  = (state_q == S_HOLD) && (state_d == S_RUN);
  end

  // Output stage: reload from the FIFO head unless a write is stalled
  always_comb begin
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (dl_start) begin
      mem_we_d = 1'b0;
    end else if (out_load) begin
      mem_we_d = (count_q != '0);
      if (count_q != '0) begin
        mem_addr_d = head.addr;
        mem_data_d = head.data;
      end
    end
  end

  // Statistics: cleared by a new download, updated by accepted bytes
  always_comb begin
    checksum_d   = dl_start ? '0 : checksum_q;
    byte_count_d = dl_start ? '0 : byte_count_q;
    overflow_d   = dl_start ? 1'b0 : overflow_q;
    if (push) begin
      checksum_d = checksum_d + {8'h00, ioctl_dout};
      if (byte_count_d != '1) byte_count_d = byte_count_d + 18'd1;
    end
    if (drop) overflow_d = 1'b1;
  end

  // Control and datapath registers
  always_ff @(posedge clock_12 or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      dl_prev_q    <= 1'b0;
      hold_cnt_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      ioctl_wait_q <= 1'b0;
      core_hold_q  <= 1'b1;
      load_done_q  <= 1'b0;
      checksum_q   <= '0;
      byte_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of the others, independent of statement order.
      state_q      <= state_d;
      dl_prev_q    <= ioctl_download;
      hold_cnt_q   <= hold_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      ioctl_wait_q <= ioctl_wait_d;
      core_hold_q  <= core_hold_d;
      load_done_q  <= load_done_d;
      checksum_q   <= checksum_d;
      byte_count_q <= byte_count_d;
      overflow_q   <= overflow_d;
    end
  end

  // FIFO storage write
  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, so stale contents are never read.
  always_ff @(posedge clock_12) begin
    if (push) fifo_mem[wr_ptr_eff] <= '{addr: ioctl_addr, data: ioctl_dout};
  end

  assign ioctl_wait = ioctl_wait_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;
  assign core_hold  = core_hold_q;
  assign load_done  = load_done_q;
  assign checksum   = checksum_q;
  assign byte_count = byte_count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_williams2_rom_loader.sv
// Directed testbench for williams2_rom_loader.
module tb_williams2_rom_loader;

  localparam int HOLD_CYCLES = 16;

  logic        clock_12 = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [16:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait;
  logic        mem_we;
  logic [16:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_ready = 1'b1;
  logic        core_hold;
  logic        load_done;
  logic [15:0] checksum;
  logic [17:0] byte_count;
  logic        overflow;

  williams2_rom_loader #(
    .ROM_INDEX  (8'd0),
    .ROM_SIZE   (17'h1_8000),
    .FIFO_DEPTH (4),
    .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clock_12      (clock_12),
    .reset_n       (reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_wait    (ioctl_wait),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_ready     (mem_ready),
    .core_hold     (core_hold),
    .load_done     (load_done),
    .checksum      (checksum),
    .byte_count    (byte_count),
    .overflow      (overflow)
  );

  always #5 clock_12 = ~clock_12;

  typedef struct packed {
    int          cyc;
    logic [16:0] addr;
    logic [7:0]  data;
  } wr_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_n = 0;
  int   ld_count = 0;
  int   ld_cyc = -1;
  wr_t  wr_q[$];

  always @(posedge clock_12) cyc_n <= cyc_n + 1;

  // Record completed memory writes and load_done pulses mid-cycle.
  always @(negedge clock_12) begin
    if (mem_we && mem_ready) wr_q.push_back('{cyc: cyc_n, addr: mem_addr, data: mem_data});
    if (load_done) begin
      ld_count = ld_count + 1;
      ld_cyc   = cyc_n;
    end
  end

  task automatic tick();
    @(posedge clock_12);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    n_cmp++; if (ioctl_wait !== 1'b0) begin n_bad++; $display("FAIL reset_ioctl_wait: got %0h want 0", ioctl_wait); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we: got %0h want 0", mem_we); end
    n_cmp++; if (mem_addr !== 17'h0) begin n_bad++; $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); end
    n_cmp++; if (mem_data !== 8'h0) begin n_bad++; $display("FAIL reset_mem_data: got %0h want 0", mem_data); end
    n_cmp++; if (core_hold !== 1'b1) begin n_bad++; $display("FAIL reset_core_hold: got %0h want 1", core_hold); end
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL reset_load_done: got %0h want 0", load_done); end
    n_cmp++; if (checksum !== 16'h0) begin n_bad++; $display("FAIL reset_checksum: got %0h want 0", checksum); end
    n_cmp++; if (byte_count !== 18'h0) begin n_bad++; $display("FAIL reset_byte_count: got %0h want 0", byte_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %0h want 0", overflow); end
    reset_n = 1'b1;
    repeat (3) tick();
    n_cmp++; if (core_hold !== 1'b1) begin n_bad++; $display("FAIL idle_core_hold: got %0h want 1", core_hold); end
  endtask

  // 16 bytes 0x01..0x10 at addresses 0..15 with the memory always ready.
  task automatic test_basic_load();
    int wr_cyc0;
    int ld0;
    int bad_idx;
    wr_q.delete();
    ld0 = ld_count;
    mem_ready = 1'b1;
    ioctl_index = 8'd0;
    ioctl_download = 1'b1;
    tick();
    wr_cyc0 = cyc_n;
    for (int i = 0; i < 16; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 17'(i); ioctl_dout = 8'(i + 1);
      n_cmp++; if (core_hold !== 1'b1) begin n_bad++; $display("FAIL basic_hold_during_load[%0d]: got %0h want 1", i, core_hold); end
      tick();
    end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    for (int n = 0; n < 100 && ld_count == ld0; n++) tick();
    n_cmp++; if (ld_count != ld0 + 1) begin n_bad++; $display("FAIL basic_load_done_seen: got %0d pulses want 1", ld_count - ld0); end
    n_cmp++; if (wr_q.size() != 16) begin n_bad++; $display("FAIL basic_write_count: got %0d want 16", wr_q.size()); end
    bad_idx = -1;
    for (int i = 0; i < 16 && i < wr_q.size(); i++)
      if (bad_idx < 0 && (wr_q[i].addr !== 17'(i) || wr_q[i].data !== 8'(i + 1))) bad_idx = i;
    n_cmp++; if (bad_idx >= 0) begin n_bad++; $display("FAIL basic_write_order: entry %0d got %0h/%0h want %0h/%0h", bad_idx, wr_q[bad_idx].addr, wr_q[bad_idx].data, bad_idx, bad_idx + 1); end
    if (wr_q.size() > 0) begin
      n_cmp++; if (wr_q[0].cyc - wr_cyc0 != 2) begin n_bad++; $display("FAIL basic_first_write_latency: got %0d want 2", wr_q[0].cyc - wr_cyc0); end
      // Last write, one cycle for the output to empty, one DRAIN cycle, then HOLD_CYCLES of HOLD.
      n_cmp++; if (ld_cyc - wr_q[wr_q.size()-1].cyc != HOLD_CYCLES + 2) begin n_bad++; $display("FAIL basic_hold_time: got %0d want %0d", ld_cyc - wr_q[wr_q.size()-1].cyc, HOLD_CYCLES + 2); end
    end
    n_cmp++; if (checksum !== 16'h0088) begin n_bad++; $display("FAIL basic_checksum: got %0h want 0088", checksum); end
    n_cmp++; if (byte_count !== 18'd16) begin n_bad++; $display("FAIL basic_byte_count: got %0d want 16", byte_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL basic_overflow: got %0h want 0", overflow); end
    n_cmp++; if (core_hold !== 1'b0) begin n_bad++; $display("FAIL basic_core_release: got %0h want 0", core_hold); end
    n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL basic_load_done_width: got %0h want 0", load_done); end
  endtask

  // A download for another index while the core runs must be invisible.
  task automatic test_other_index();
    int ld0;
    wr_q.delete();
    ld0 = ld_count;
    ioctl_index = 8'd1;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 17'(i); ioctl_dout = 8'h5A;
      tick();
    end
    ioctl_wr = 1'b0;
    repeat (10) tick();
    n_cmp++; if (wr_q.size() != 0) begin n_bad++; $display("FAIL other_idx_writes: got %0d want 0", wr_q.size()); end
    n_cmp++; if (core_hold !== 1'b0) begin n_bad++; $display("FAIL other_idx_core_hold: got %0h want 0", core_hold); end
    n_cmp++; if (byte_count !== 18'd16) begin n_bad++; $display("FAIL other_idx_byte_count: got %0d want 16", byte_count); end
    n_cmp++; if (checksum !== 16'h0088) begin n_bad++; $display("FAIL other_idx_checksum: got %0h want 0088", checksum); end
    n_cmp++; if (ioctl_wait !== 1'b0) begin n_bad++; $display("FAIL other_idx_wait: got %0h want 0", ioctl_wait); end
    n_cmp++; if (ld_count != ld0) begin n_bad++; $display("FAIL other_idx_load_done: got %0d pulses want 0", ld_count - ld0); end
    ioctl_download = 1'b0;
    ioctl_index = 8'd0;
    tick();
  endtask

  // Memory stalls for 20 cycles while an 8-byte burst honours ioctl_wait.
  task automatic test_backpressure();
    int  sent;
    int  ld0;
    int  bad_idx;
    bit  unstable;
    wr_q.delete();
    ld0 = ld_count;
    mem_ready = 1'b0;
    ioctl_download = 1'b1;
    tick();
    n_cmp++; if (byte_count !== 18'd0) begin n_bad++; $display("FAIL bp_count_cleared: got %0d want 0", byte_count); end
    n_cmp++; if (checksum !== 16'h0) begin n_bad++; $display("FAIL bp_checksum_cleared: got %0h want 0", checksum); end
    sent = 0;
    unstable = 1'b0;
    for (int t = 0; t < 200 && (sent < 8 || t < 21); t++) begin
      mem_ready = (t >= 20);
      if (t >= 3 && t <= 19 && !(mem_we === 1'b1 && mem_addr === 17'h100 && mem_data === 8'hA0)) unstable = 1'b1;
      if (t == 19) begin
        n_cmp++; if (sent != 4) begin n_bad++; $display("FAIL bp_bytes_before_wait: got %0d want 4", sent); end
        n_cmp++; if (ioctl_wait !== 1'b1) begin n_bad++; $display("FAIL bp_wait_asserted: got %0h want 1", ioctl_wait); end
      end
      if (sent < 8 && ioctl_wait === 1'b0) begin
        ioctl_wr = 1'b1; ioctl_addr = 17'h100 + 17'(sent); ioctl_dout = 8'hA0 + 8'(sent);
        sent++;
      end else begin
        ioctl_wr = 1'b0;
      end
      tick();
    end
    ioctl_wr = 1'b0;
    n_cmp++; if (unstable) begin n_bad++; $display("FAIL bp_output_stable: got changing output want 100/A0 held"); end
    for (int n = 0; n < 50 && wr_q.size() < 8; n++) tick();
    n_cmp++; if (wr_q.size() != 8) begin n_bad++; $display("FAIL bp_write_count: got %0d want 8", wr_q.size()); end
    bad_idx = -1;
    for (int i = 0; i < 8 && i < wr_q.size(); i++)
      if (bad_idx < 0 && (wr_q[i].addr !== 17'h100 + 17'(i) || wr_q[i].data !== 8'hA0 + 8'(i))) bad_idx = i;
    n_cmp++; if (bad_idx >= 0) begin n_bad++; $display("FAIL bp_write_order: entry %0d got %0h/%0h", bad_idx, wr_q[bad_idx].addr, wr_q[bad_idx].data); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL bp_overflow: got %0h want 0", overflow); end
    n_cmp++; if (byte_count !== 18'd8) begin n_bad++; $display("FAIL bp_byte_count: got %0d want 8", byte_count); end
    n_cmp++; if (checksum !== 16'h051C) begin n_bad++; $display("FAIL bp_checksum: got %0h want 051c", checksum); end
    ioctl_download = 1'b0;
    for (int n = 0; n < 100 && ld_count == ld0; n++) tick();
    n_cmp++; if (ld_count != ld0 + 1) begin n_bad++; $display("FAIL bp_load_done: got %0d pulses want 1", ld_count - ld0); end
  endtask

  // Out-of-range address plus a sender ignoring ioctl_wait into a full FIFO.
  task automatic test_overflow();
    int ld0;
    int bad_idx;
    wr_q.delete();
    ld0 = ld_count;
    mem_ready = 1'b0;
    ioctl_download = 1'b1;
    tick();
    ioctl_wr = 1'b1; ioctl_addr = 17'h1_8000; ioctl_dout = 8'h77;
    tick();
    for (int i = 0; i < 6; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 17'h200 + 17'(i); ioctl_dout = 8'h10 * 8'(i + 1);
      tick();
    end
    ioctl_wr = 1'b0;
    tick();
    // 0x10..0x50 fit (one in the output register, four queued); 0x60 is dropped.
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %0h want 1", overflow); end
    n_cmp++; if (byte_count !== 18'd5) begin n_bad++; $display("FAIL ovf_byte_count: got %0d want 5", byte_count); end
    n_cmp++; if (checksum !== 16'h00F0) begin n_bad++; $display("FAIL ovf_checksum: got %0h want 00f0", checksum); end
    n_cmp++; if (ioctl_wait !== 1'b1) begin n_bad++; $display("FAIL ovf_wait: got %0h want 1", ioctl_wait); end
    mem_ready = 1'b1;
    for (int n = 0; n < 30 && wr_q.size() < 5; n++) tick();
    repeat (5) tick();
    n_cmp++; if (wr_q.size() != 5) begin n_bad++; $display("FAIL ovf_write_count: got %0d want 5", wr_q.size()); end
    bad_idx = -1;
    for (int i = 0; i < 5 && i < wr_q.size(); i++)
      if (bad_idx < 0 && (wr_q[i].addr !== 17'h200 + 17'(i) || wr_q[i].data !== 8'h10 * 8'(i + 1))) bad_idx = i;
    n_cmp++; if (bad_idx >= 0) begin n_bad++; $display("FAIL ovf_write_order: entry %0d got %0h/%0h", bad_idx, wr_q[bad_idx].addr, wr_q[bad_idx].data); end
    ioctl_download = 1'b0;
    for (int n = 0; n < 100 && ld_count == ld0; n++) tick();
    n_cmp++; if (ld_count != ld0 + 1) begin n_bad++; $display("FAIL ovf_load_done: got %0d pulses want 1", ld_count - ld0); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %0h want 1", overflow); end
    // An empty new download clears the statistics.
    ld0 = ld_count;
    ioctl_download = 1'b1;
    tick();
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL restart_overflow_clear: got %0h want 0", overflow); end
    n_cmp++; if (byte_count !== 18'd0) begin n_bad++; $display("FAIL restart_count_clear: got %0d want 0", byte_count); end
    n_cmp++; if (core_hold !== 1'b1) begin n_bad++; $display("FAIL restart_core_hold: got %0h want 1", core_hold); end
    ioctl_download = 1'b0;
    for (int n = 0; n < 100 && ld_count == ld0; n++) tick();
    n_cmp++; if (ld_count != ld0 + 1) begin n_bad++; $display("FAIL restart_load_done: got %0d pulses want 1", ld_count - ld0); end
  endtask

  // Reset asserted mid-LOAD with bytes pending.
  task automatic test_reset_mid_load();
    int ld0;
    mem_ready = 1'b0;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 17'h300 + 17'(i); ioctl_dout = 8'hC0 + 8'(i);
      tick();
    end
    ioctl_wr = 1'b0;
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL midrst_pending_we: got %0h want 1", mem_we); end
    #2;
    reset_n = 1'b0;
    ioctl_download = 1'b0;
    #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL midrst_mem_we: got %0h want 0", mem_we); end
    n_cmp++; if (core_hold !== 1'b1) begin n_bad++; $display("FAIL midrst_core_hold: got %0h want 1", core_hold); end
    n_cmp++; if (ioctl_wait !== 1'b0) begin n_bad++; $display("FAIL midrst_wait: got %0h want 0", ioctl_wait); end
    n_cmp++; if (byte_count !== 18'd0) begin n_bad++; $display("FAIL midrst_byte_count: got %0d want 0", byte_count); end
    tick();
    tick();
    reset_n = 1'b1;
    mem_ready = 1'b1;
    wr_q.delete();
    ld0 = ld_count;
    repeat (40) tick();
    n_cmp++; if (ld_count != ld0) begin n_bad++; $display("FAIL midrst_no_load_done: got %0d pulses want 0", ld_count - ld0); end
    n_cmp++; if (wr_q.size() != 0) begin n_bad++; $display("FAIL midrst_bytes_lost: got %0d writes want 0", wr_q.size()); end
    n_cmp++; if (core_hold !== 1'b1) begin n_bad++; $display("FAIL midrst_idle_hold: got %0h want 1", core_hold); end
  endtask

  // 70000 bytes of 0xFF: checksum wraps, count exceeds 16 bits.
  task automatic test_large_load();
    int          ld0;
    logic [15:0] exp_sum;
    wr_q.delete();
    ld0 = ld_count;
    exp_sum = 16'h0;
    mem_ready = 1'b1;
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 70000; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 17'(i); ioctl_dout = 8'hFF;
      exp_sum = exp_sum + 16'h00FF;
      tick();
    end
    ioctl_wr = 1'b0;
    ioctl_download = 1'b0;
    for (int n = 0; n < 200 && ld_count == ld0; n++) tick();
    n_cmp++; if (ld_count != ld0 + 1) begin n_bad++; $display("FAIL big_load_done: got %0d pulses want 1", ld_count - ld0); end
    // 70000 * 255 = 17850000 = 0x1105E90, so the low 16 bits are 0x5E90.
    n_cmp++; if (checksum !== exp_sum) begin n_bad++; $display("FAIL big_checksum: got %0h want %0h", checksum, exp_sum); end
    n_cmp++; if (byte_count !== 18'd70000) begin n_bad++; $display("FAIL big_byte_count: got %0d want 70000", byte_count); end
    n_cmp++; if (wr_q.size() != 70000) begin n_bad++; $display("FAIL big_write_count: got %0d want 70000", wr_q.size()); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL big_overflow: got %0h want 0", overflow); end
    n_cmp++; if (core_hold !== 1'b0) begin n_bad++; $display("FAIL big_core_release: got %0h want 0", core_hold); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_other_index();
    test_backpressure();
    test_overflow();
    test_reset_mid_load();
    test_large_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
